// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder end of the CPU data-memory interface. Takes one load/store at a
//   time over a valid/ready request channel, waits WAIT_CYCLES wait states,
//   performs the access on the word-addressed RAM, then presents the result on
//   a valid/ready response channel until the requester takes it.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_write         1 = store, 0 = load
//   req_addr          byte address (must be word aligned and inside the RAM)
//   req_wdata/wstrb   store data and byte enables (wstrb[i] -> bits 8i+7:8i)
//   rsp_valid/ready   response handshake
//   rsp_rdata         load data; 0 for stores and errors
//   rsp_err           misaligned or out-of-range request
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        acc_en;

   // request fields captured at the handshake
   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_wstrb;

   // fields used for the access; with no wait states the access happens on
   // the handshake edge itself, so the live request is used directly
   logic          acc_write;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_wstrb;
   logic          acc_err;
   logic [AW-1:0] acc_idx;

   logic [31:0] mem [DEPTH_WORDS];

   // held low throughout reset, and the reset state is IDLE
   assign req_ready = rst & (state == S_IDLE);

   always_comb begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
      if (state == S_IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wstrb = req_wstrb;
      end
   end

   // upper address bits only feed the range check; the RAM index never wraps
   assign acc_err = (acc_addr[1:0] != 2'b00) | (acc_addr[31:2] >= 30'(DEPTH_WORDS));
   assign acc_idx = acc_addr[AW+1:2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rsp_valid = 1'b0;
      acc_en    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = S_RESP;
                  acc_en    = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = S_RESP;
               acc_en    = 1'b1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= 4'd0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (state == S_IDLE && req_valid && req_ready) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            cnt       <= CNT_INIT;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         if (acc_en) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (!acc_write && !acc_err) ? mem[acc_idx] : 32'd0;
         end else if (rsp_valid && rsp_ready) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
         end
      end
   end

   // RAM is not reset; a reset before the access edge simply never gets here
   always_ff @(posedge clk) begin
      if (acc_en && acc_write && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   // instance 0: two wait states, instance 1: none
   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   int wcy [2] = '{2, 0};
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference memory contents, one per instance
   logic [31:0] mdl [2][DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: apply one request to the model, return the expected response.
   task automatic model(input int s, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic [31:0] rd, output bit err);
      logic [31:0] widx;
      widx = addr / 4;
      err  = (addr % 4 != 0) || (widx >= DEPTH);
      rd   = 32'd0;
      if (!err) begin
         if (wr) begin
            for (int i = 0; i < 4; i++)
               if (wstrb[i]) mdl[s][widx][8*i +: 8] = wdata[8*i +: 8];
         end else begin
            rd = mdl[s][widx];
         end
      end
   endtask

   // One full transaction. dly > 0 holds rsp_ready low that many cycles while
   // also presenting a stray request that must be ignored.
   task automatic xact(input int s, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input int dly, output int acc_cyc, output logic [31:0] rd);
      logic [31:0] exp_rd;
      bit          exp_err;
      int          n;
      model(s, wr, addr, wdata, wstrb, exp_rd, exp_err);
      req_valid[s] = 1'b1;
      req_write[s] = wr;
      req_addr[s]  = addr;
      req_wdata[s] = wdata;
      req_wstrb[s] = wstrb;
      rsp_ready[s] = (dly == 0);
      n = 0;
      while (req_ready[s] !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      req_valid[s] = 1'b0;
      chk("req_ready_drop", 32'(req_ready[s]), 32'd0);
      n = 0;
      while (rsp_valid[s] !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", n + 1, wcy[s] + 1);
      chk("rsp_err", 32'(rsp_err[s]), 32'(exp_err));
      chk("rsp_rdata", rsp_rdata[s], exp_rd);
      rd = rsp_rdata[s];
      for (int k = 0; k < dly; k++) begin
         req_valid[s] = 1'b1;
         @(posedge clk); #1;
         chk("stall_valid", 32'(rsp_valid[s]), 32'd1);
         chk("stall_rdata", rsp_rdata[s], exp_rd);
         chk("stall_req_ready", 32'(req_ready[s]), 32'd0);
      end
      req_valid[s] = 1'b0;
      rsp_ready[s] = 1'b1;
      @(posedge clk); #1;
      chk("rsp_drop", 32'(rsp_valid[s]), 32'd0);
      chk("rsp_rdata_clr", rsp_rdata[s], 32'd0);
      chk("rsp_err_clr", 32'(rsp_err[s]), 32'd0);
      chk("req_ready_back", 32'(req_ready[s]), 32'd1);
      rsp_ready[s] = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       return 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (r == 7) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) return 32'($urandom_range(DEPTH, DEPTH + 100)) * 4;
      else             return $urandom;
   endfunction

   initial begin
      int c0, c1;
      logic [31:0] rd;

      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 0; req_write[s] = 0; req_addr[s] = 0;
         req_wdata[s] = 0; req_wstrb[s] = 0; rsp_ready[s] = 0;
      end

      // reset values
      #2 rst = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst_req_ready", 32'(req_ready[s]), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
         chk("rst_rsp_rdata", rsp_rdata[s], 32'd0);
         chk("rst_rsp_err", 32'(rsp_err[s]), 32'd0);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rel_req_ready0", 32'(req_ready[0]), 32'd1);
      chk("rel_req_ready1", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;

      // give the RAMs defined contents
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < DEPTH; w++)
            xact(s, 1'b1, 32'(w) * 4, 32'd0, 4'hF, 0, c0, rd);

      // directed, two wait states
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, c0, rd);
      xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, c1, rd);
      chk("store_load", rd, 32'hDEADBEEF);
      chk("spacing_w2", c1 - c0, 4);
      xact(0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 0, c0, rd);
      xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, c0, rd);
      chk("byte_strobe", rd, 32'hDEAABEEF);
      xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0000, 0, c0, rd);
      xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, c0, rd);
      chk("zero_strobe", rd, 32'hDEAABEEF);
      xact(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, c0, rd);
      xact(0, 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 0, c0, rd);
      xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, c0, rd);
      chk("oor_no_write", rd, 32'h0);

      // back-pressure for 10 cycles during a load response
      xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 10, c0, rd);
      chk("bp_rdata", rd, 32'hDEAABEEF);

      // no wait states: back-to-back loads
      xact(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 0, c0, rd);
      xact(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, c0, rd);
      xact(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, c1, rd);
      chk("spacing_w0", c1 - c0, 2);
      chk("w0_load", rd, 32'hCAFEF00D);

      // randomized traffic against the model
      for (int t = 0; t < 80; t++)
         xact(0, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, c0, rd);
      for (int t = 0; t < 60; t++)
         xact(1, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, c0, rd);

      // reset during the wait states of a store aborts it
      xact(0, 1'b1, 32'h20, 32'h0, 4'hF, 0, c0, rd);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
      req_wdata[0] = 32'h12345678; req_wstrb[0] = 4'hF;
      chk("abort_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("abort_rsp_rdata", rsp_rdata[0], 32'd0);
      chk("abort_rsp_err", 32'(rsp_err[0]), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, c0, rd);
      chk("abort_no_write", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
